psram_mp: RTL and testbench

PSRAM_MP -- requirements
Module: psram_mp

---
 rtl/psram_mp.sv | 237 +++++++++++++++++++++++
 tb/tb_psram_mp.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_mp.sv
// psram_mp -- multi-port arbiter and asynchronous-mode controller for a
// two-bank 16-bit cellular PSRAM.
//
// Up to four requesters share the memory. A round-robin arbiter picks one
// pending request while the controller is idle. The request is acknowledged
// combinationally in that same cycle. Then a fixed-length address/data
// sequence is played out on the PSRAM pins. Reads return data on the shared
// rdata bus, and the granted port's rvalid pulses one cycle after capture.
//
// Ports:
//   clk, reset         system clock (rising edge), async active-high reset
//   req/we             per-port request and write flag
//   address            per-port word address; MSB selects the bank (CE0/CE1)
//   wdata/wr_be        per-port write data and byte enables (bit1 = upper)
//   ack/rvalid         per-port request accepted / read data valid
//   rdata              shared read data, held until the next read capture
//   cram_*             PSRAM pins (cram_wait is unused)
//
// Optional feature macro: PSRAM_MP_BYTE_MASK_EN
//   defined   -> write byte lanes follow wr_be; reads enable both bytes
//   undefined -> UB#/LB# simply follow CE# for every access
module psram_mp #(
  parameter int CLK_FREQ        = 40000000,
  parameter int RAM_CYCLE_NANOS = 72,
  parameter int PORTS           = 2,
  parameter int ADDRESS_BITS    = 23,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [PORTS-1:0]                     req,
  input  logic [PORTS-1:0]                     we,
  input  logic [PORTS-1:0][ADDRESS_BITS-1:0]   address,
  input  logic [PORTS-1:0][15:0]               wdata,
  input  logic [PORTS-1:0][1:0]                wr_be,
  output logic [PORTS-1:0]                     ack,
  output logic [PORTS-1:0]                     rvalid,
  output logic [15:0]                          rdata,
  output logic [ADDRESS_BITS-18:0]             cram_a,
  inout  wire  [15:0]                          cram_dq,
  input  logic                                 cram_wait,
  output logic                                 cram_clk,
  output logic                                 cram_adv_n,
  output logic                                 cram_cre,
  output logic                                 cram_ce0_n,
  output logic                                 cram_ce1_n,
  output logic                                 cram_oe_n,
  output logic                                 cram_we_n,
  output logic                                 cram_ub_n,
  output logic                                 cram_lb_n
);

  // Access length in clocks. The product is formed in 64 bits because it
  // exceeds 32 bits at ordinary clock rates.
  localparam longint unsigned CYCLE_PROD = 64'(RAM_CYCLE_NANOS) * 64'(CLK_FREQ);
  localparam longint unsigned CYCLE_CEIL = (CYCLE_PROD + 64'd999999999) / 64'd1000000000;
  localparam int N  = (CYCLE_CEIL < 64'd3) ? 3 : int'(CYCLE_CEIL);
  localparam int CW = $clog2(N);
  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;

  typedef enum logic [2:0] {
    IDLE, RD_ADV, RD_OE, WR_ADV, WR_HOLD, WR_DATA, RECOVER
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           last_q, last_d;
  logic [PORTS-1:0]        grant_q, grant_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [15:0]             wdata_q, wdata_d;
  logic [1:0]              be_q, be_d;
  logic [15:0]             rdata_q, rdata_d;
  logic [PORTS-1:0]        rvalid_q, rvalid_d;

  logic                    found;
  logic [PW-1:0]           pick;
  logic [PORTS-1:0]        pick_oh;
  logic                    pick_we;
  logic [ADDRESS_BITS-1:0] pick_addr;
  logic [15:0]             pick_wdata;
  logic [1:0]              pick_be;
  logic                    last_cyc;
  logic                    ce_n, we_n, adv_n, oe_n, bank;
  logic                    unused_sigs;

  // Round-robin pick: scan from the port after the last grant, wrapping
  // around, and take the first one requesting. The selected port's request
  // fields are muxed out here, so no variable indexing is needed elsewhere.
  always_comb begin
    found      = 1'b0;
    pick       = last_q;
    pick_oh    = '0;
    pick_we    = 1'b0;
    pick_addr  = '0;
    pick_wdata = '0;
    pick_be    = '0;
    for (int i = 1; i <= PORTS; i++) begin
      for (int p = 0; p < PORTS; p++) begin
        if (!found && req[p] && (p == (int'(last_q) + i) % PORTS)) begin
          found      = 1'b1;
          pick       = PW'(p);
          pick_oh[p] = 1'b1;
          pick_we    = we[p];
          pick_addr  = address[p];
          pick_wdata = wdata[p];
          pick_be    = wr_be[p];
        end
      end
    end
  end

  assign last_cyc = (cnt_q == CW'(N - 1));

  // Sequencer next state. The counter runs through every non-idle cycle.
  // The final access cycle is counter N-1. Recovery reuses the same counter
  // after clearing it.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    last_d   = last_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (found) begin
          last_d  = pick;
          grant_d = pick_oh;
          addr_d  = pick_addr;
          wdata_d = pick_wdata;
          be_d    = pick_be;
          state_d = pick_we ? WR_ADV : RD_ADV;
        end
      end
      RD_ADV:  state_d = RD_OE;
      WR_ADV:  state_d = WR_HOLD;
      WR_HOLD: state_d = WR_DATA;
      RD_OE, WR_DATA: begin
        if (last_cyc) begin
          cnt_d   = '0;
          state_d = (RECOVERY_CYCLES == 0) ? IDLE : RECOVER;
          if (state_q == RD_OE) begin
            rdata_d  = cram_dq;
            rvalid_d = grant_q;
          end
        end
      end
      RECOVER: begin
        if (cnt_q == CW'(RECOVERY_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset drops any access in flight, so a
  // read aborted mid-way never produces an rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= PW'(PORTS - 1);
      grant_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Pin levels are decoded straight from the state register. Because reset
  // forces the state register asynchronously, the strobes deassert as soon
  // as reset rises.
  always_comb begin
    ce_n  = 1'b1;
    we_n  = 1'b1;
    adv_n = 1'b1;
    oe_n  = 1'b1;
    case (state_q)
      RD_ADV:           begin ce_n = 1'b0; adv_n = 1'b0; end
      RD_OE:            begin ce_n = 1'b0; oe_n  = 1'b0; end
      WR_ADV:           begin ce_n = 1'b0; we_n  = 1'b0; adv_n = 1'b0; end
      WR_HOLD, WR_DATA: begin ce_n = 1'b0; we_n  = 1'b0; end
      default:          ;
    endcase
  end

  // The low address bits travel on DQ (address/data multiplexed bus). DQ
  // floats only while the memory is driving read data.
  assign bank       = addr_q[ADDRESS_BITS-1];
  assign cram_ce0_n = ce_n | bank;
  assign cram_ce1_n = ce_n | ~bank;
  assign cram_we_n  = we_n;
  assign cram_adv_n = adv_n;
  assign cram_oe_n  = oe_n;
  assign cram_a     = addr_q[ADDRESS_BITS-2:16];
  assign cram_dq    = (state_q == RD_OE) ? 16'hzzzz
                    : ((state_q == WR_DATA) ? wdata_q : addr_q[15:0]);
  assign cram_clk   = 1'b0;
  assign cram_cre   = 1'b0;

`ifdef PSRAM_MP_BYTE_MASK_EN
  // Write cycles gate each byte lane with its enable. Read cycles open both
  // lanes, and idle keeps both lanes closed.
  assign cram_ub_n   = (!we_n) ? ~be_q[1] : ce_n;
  assign cram_lb_n   = (!we_n) ? ~be_q[0] : ce_n;
  assign unused_sigs = cram_wait;
`else
  assign cram_ub_n   = ce_n;
  assign cram_lb_n   = ce_n;
  assign unused_sigs = ^{cram_wait, be_q};
`endif

  // Reset is included here so that ack stays low during reset, even if a
  // request is already pending.
  assign ack    = (state_q == IDLE && !reset) ? pick_oh : '0;
  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_psram_mp.sv
// tb_psram_mp -- randomized self-checking bench for psram_mp.
//
// Two instances are used. The main instance uses default parameters
// (N = 3, one recovery cycle). It has a pin-level PSRAM model and
// randomized two-port traffic. Every cycle it is compared against a
// transaction-level reference: round-robin grant order, access timeline,
// expected pin levels, and a shadow memory. The second instance runs at
// 100 MHz (N = 8) and checks only read latency.
// When PSRAM_MP_BYTE_MASK_EN is defined, the byte-lane expectations change.
module tb_psram_mp;

  localparam int N = 3;
  localparam int R = 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req, we;
  logic [1:0][22:0] address;
  logic [1:0][15:0] wdata;
  logic [1:0][1:0]  wr_be;
  logic [1:0]       ack, rvalid;
  logic [15:0]      rdata;
  logic [5:0]       cram_a;
  wire  [15:0]      cram_dq;
  logic             cram_wait = 1'b0;
  logic cram_clk, cram_adv_n, cram_cre, cram_ce0_n, cram_ce1_n;
  logic cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n;

  logic [1:0]       f_req, f_we;
  logic [1:0][22:0] f_addr;
  logic [1:0][15:0] f_wdata;
  logic [1:0][1:0]  f_be;
  logic [1:0]       f_ack, f_rvalid;
  logic [15:0]      f_rdata;
  logic [5:0]       f_a;
  wire  [15:0]      f_dq;
  logic f_clk, f_adv_n, f_cre, f_ce0_n, f_ce1_n, f_oe_n, f_we_n, f_ub_n, f_lb_n;

  int checks = 0;
  int failures = 0;

  psram_mp u_dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .address(address),
    .wdata(wdata), .wr_be(wr_be), .ack(ack), .rvalid(rvalid), .rdata(rdata),
    .cram_a(cram_a), .cram_dq(cram_dq), .cram_wait(cram_wait),
    .cram_clk(cram_clk), .cram_adv_n(cram_adv_n), .cram_cre(cram_cre),
    .cram_ce0_n(cram_ce0_n), .cram_ce1_n(cram_ce1_n), .cram_oe_n(cram_oe_n),
    .cram_we_n(cram_we_n), .cram_ub_n(cram_ub_n), .cram_lb_n(cram_lb_n)
  );

  psram_mp #(.CLK_FREQ(100000000)) u_fast (
    .clk(clk), .reset(reset), .req(f_req), .we(f_we), .address(f_addr),
    .wdata(f_wdata), .wr_be(f_be), .ack(f_ack), .rvalid(f_rvalid), .rdata(f_rdata),
    .cram_a(f_a), .cram_dq(f_dq), .cram_wait(cram_wait),
    .cram_clk(f_clk), .cram_adv_n(f_adv_n), .cram_cre(f_cre),
    .cram_ce0_n(f_ce0_n), .cram_ce1_n(f_ce1_n), .cram_oe_n(f_oe_n),
    .cram_we_n(f_we_n), .cram_ub_n(f_ub_n), .cram_lb_n(f_lb_n)
  );

  always #5 clk = ~clk;

  // Contents assumed for locations that have never been written.
  function automatic logic [15:0] defval(bit [22:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Pin-level PSRAM model. The address is latched while ADV# is low. The
  // write data and byte lanes seen during the WE#-low data phase are
  // committed once WE# returns high. The model drives DQ while OE# is low.
  logic [15:0] pmem [bit [22:0]];
  bit   [22:0] m_addr;
  logic [15:0] m_rdval, m_data;
  logic        m_ub, m_lb;
  bit          m_pend = 1'b0;

  always @(negedge clk) begin
    if (!cram_adv_n && (!cram_ce0_n || !cram_ce1_n)) begin
      m_addr  = {!cram_ce1_n, cram_a, cram_dq};
      m_rdval = pmem.exists(m_addr) ? pmem[m_addr] : defval(m_addr);
    end
    if (!cram_we_n && cram_adv_n) begin
      m_data = cram_dq;
      m_ub   = cram_ub_n;
      m_lb   = cram_lb_n;
      m_pend = 1'b1;
    end else if (m_pend && cram_we_n) begin
      logic [15:0] v;
      v = pmem.exists(m_addr) ? pmem[m_addr] : defval(m_addr);
      if (!m_ub) v[15:8] = m_data[15:8];
      if (!m_lb) v[7:0]  = m_data[7:0];
      pmem[m_addr] = v;
      m_pend = 1'b0;
    end
  end

  assign cram_dq = (!cram_oe_n && (!cram_ce0_n || !cram_ce1_n)) ? m_rdval : 16'hzzzz;

  // Reference state: the single access in flight and the shadow memory.
  logic [15:0] exp_mem [bit [22:0]];
  int          cyc, t0, next_free, exp_last, cport;
  bit          busy, cwr, got_ack;
  logic [22:0] caddr, lat_addr;
  logic [15:0] cdata, exp_rdata;
  logic [1:0]  cbe, acked;
  logic [22:0] pool [8] = '{23'h400123, 23'h000010, 23'h400010, 23'h000123,
                            23'h7FFFFF, 23'h000000, 23'h3F0A55, 23'h412345};

  // All comparisons go through this task.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic modelReset();
    busy      = 1'b0;
    exp_last  = 1;
    lat_addr  = '0;
    exp_rdata = '0;
  endtask

  function automatic logic [15:0] shadowRead(bit [22:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : defval(a);
  endfunction

  task automatic newTxn(input int p);
    we[p]      = 1'($urandom_range(1));
    address[p] = pool[$urandom_range(7)];
    wdata[p]   = 16'($urandom);
    wr_be[p]   = 2'($urandom_range(3));
    req[p]     = 1'b1;
  endtask

  // Requesters drop req after the edge that follows their ack. An idle
  // requester raises a new request with probability pct percent.
  task automatic applyStimulus(input int pct);
    for (int p = 0; p < 2; p++) begin
      if (acked[p]) req[p] = 1'b0;
      if (!req[p] && $urandom_range(99) < pct) newTxn(p);
    end
    acked = '0;
  endtask

  // Per-cycle comparison against the transaction-level reference.
  task automatic compareCycle();
    int k;
    bit act, ce_n, we_n, adv_n, oe_n, ub, lb, bk;
    logic [1:0] exp_ack, exp_rv;
    logic [15:0] exp_dq;
    if (reset) modelReset();
    k     = cyc - t0;
    act   = busy && k >= 1 && k <= N;
    ce_n  = !act;
    we_n  = !(act && cwr);
    adv_n = !(act && k == 1);
    oe_n  = !(act && !cwr && k >= 2);
    bk    = lat_addr[22];
`ifdef PSRAM_MP_BYTE_MASK_EN
    if (act && cwr) {ub, lb} = ~cbe;
    else            {ub, lb} = {ce_n, ce_n};
`else
    {ub, lb} = {ce_n, ce_n};
`endif
    checkOutput("pins", {cram_clk, cram_cre, cram_ce0_n, cram_ce1_n, cram_we_n,
                         cram_adv_n, cram_oe_n, cram_ub_n, cram_lb_n},
                {2'b00, ce_n | bk, ce_n | !bk, we_n, adv_n, oe_n, ub, lb});
    checkOutput("cram_a", cram_a, lat_addr[21:16]);
    if (oe_n) begin
      exp_dq = (act && cwr && k >= 3) ? cdata : lat_addr[15:0];
      checkOutput("dq", cram_dq, exp_dq);
    end
    exp_rv = '0;
    if (busy && !cwr && k == N + 1) begin
      exp_rv[cport] = 1'b1;
      exp_rdata     = cdata;
    end
    checkOutput("rvalid", rvalid, exp_rv);
    checkOutput("rdata", rdata, exp_rdata);
    if (busy && cyc >= next_free) busy = 1'b0;
    exp_ack = '0;
    if (!reset && !busy) begin
      for (int i = 1; i <= 2; i++) begin
        int p;
        p = (exp_last + i) % 2;
        if (req[p]) begin
          exp_ack[p] = 1'b1;
          exp_last   = p;
          break;
        end
      end
    end
    checkOutput("ack", ack, exp_ack);
    if (exp_ack != 2'b00) begin
      cport     = exp_last;
      busy      = 1'b1;
      t0        = cyc;
      next_free = cyc + N + R + 1;
      cwr       = we[cport];
      caddr     = address[cport];
      cbe       = wr_be[cport];
      lat_addr  = caddr;
      if (cwr) begin
        logic [15:0] v;
        cdata = wdata[cport];
`ifdef PSRAM_MP_BYTE_MASK_EN
        v = shadowRead(caddr);
        if (cbe[1]) v[15:8] = cdata[15:8];
        if (cbe[0]) v[7:0]  = cdata[7:0];
`else
        v = cdata;
`endif
        exp_mem[caddr] = v;
      end else begin
        cdata = shadowRead(caddr);
      end
    end
    acked = ack;
    if (ack != 2'b00) got_ack = 1'b1;
  endtask

  task automatic stepCycle(input int pct);
    @(posedge clk);
    cyc++;
    #1;
    applyStimulus(pct);
    @(negedge clk);
    compareCycle();
  endtask

  initial begin
    int n, oe_cnt, rv_at;
    reset   = 1'b1;
    acked   = '0;
    f_req   = '0; f_we = '0; f_addr = '0; f_wdata = '0; f_be = '0;
    cyc     = 0;
    t0      = 0;
    got_ack = 1'b0;
    modelReset();
    pmem[23'h400123]    = 16'hBEEF;
    exp_mem[23'h400123] = 16'hBEEF;

    // The first two requests are scripted: port 0 reads 0x400123 and
    // port 1 writes 0x1234 to 0x000010. Both are raised while reset is held.
    req = 2'b11; we = 2'b10;
    address[0] = 23'h400123; wdata[0] = 16'h0000; wr_be[0] = 2'b11;
    address[1] = 23'h000010; wdata[1] = 16'h1234; wr_be[1] = 2'b11;
    @(negedge clk);
    compareCycle();
    @(posedge clk);
    cyc++;
    #1 reset = 1'b0;
    @(negedge clk);
    compareCycle();
    for (int i = 0; i < 14; i++) stepCycle(0);

    // Both ports request continuously, followed by sparse random traffic
    // and a drain.
    for (int i = 0; i < 60; i++) stepCycle(100);
    for (int i = 0; i < 300; i++) stepCycle(30);
    for (int i = 0; i < 30; i++) stepCycle(0);

    // Raise a read, then assert reset during its first OE# cycle.
    @(posedge clk);
    cyc++;
    #1;
    applyStimulus(0);
    we[0] = 1'b0; address[0] = 23'h400123; req[0] = 1'b1;
    got_ack = 1'b0;
    @(negedge clk);
    compareCycle();
    n = 0;
    while (!got_ack && n < 20) begin
      stepCycle(0);
      n++;
    end
    checkOutput("abort_read_granted", got_ack, 1'b1);
    stepCycle(0);
    stepCycle(0);
    checkOutput("abort_in_rd_oe", cram_oe_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_ce_oe_high", {cram_ce0_n, cram_ce1_n, cram_oe_n, cram_adv_n}, 4'hF);
    checkOutput("reset_dq_zero", cram_dq, 16'h0000);
    stepCycle(0);
    stepCycle(0);
    @(posedge clk);
    cyc++;
    #1 reset = 1'b0;
    applyStimulus(0);
    @(negedge clk);
    compareCycle();
    for (int i = 0; i < 80; i++) stepCycle(40);
    for (int i = 0; i < 30; i++) stepCycle(0);

    // With a 100 MHz clock, N is 8. The access has 1 ADV cycle and 7 OE
    // cycles, and rvalid arrives 9 cycles after ack.
    @(posedge clk);
    #1;
    f_addr[0] = 23'h400123; f_we = '0; f_req = 2'b01;
    n = 0;
    @(negedge clk);
    while (f_ack[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("fast_ack", f_ack, 2'b01);
    oe_cnt = 0;
    rv_at  = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk);
      #1;
      if (j == 1) f_req = '0;
      @(negedge clk);
      if (!f_oe_n) oe_cnt++;
      if (f_rvalid[0] && rv_at == 0) rv_at = j;
    end
    checkOutput("fast_rvalid_latency", rv_at, 9);
    checkOutput("fast_oe_cycles", oe_cnt, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
